// File: rtl/ram8_regbank16_if.sv
// Write/read bus of the RAM8 storage stage: demux-side write port, registered read port.
interface ram8_regbank16_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] IN;
  logic [2:0]       WADDR;
  logic             LOAD;
  logic [2:0]       RADDR;
  logic             RD_EN;
  logic             CLR;
  logic [WIDTH-1:0] OUT;
  logic             OUT_VALID;
  logic [7:0]       WRITTEN;
  logic             RD_UNINIT;

  modport master (
    output IN, WADDR, LOAD, RADDR, RD_EN, CLR,
    input  OUT, OUT_VALID, WRITTEN, RD_UNINIT
  );

  modport slave (
    input  IN, WADDR, LOAD, RADDR, RD_EN, CLR,
    output OUT, OUT_VALID, WRITTEN, RD_UNINIT
  );
endinterface

// File: rtl/ram8_regbank16.sv
// Eight-word register bank: one write port fed by the address demux, one registered
// read port with valid flag, plus a per-word "written since reset/clear" map.
module ram8_regbank16 #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter bit          FWD_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  ram8_regbank16_if.slave  bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             uninit_q, uninit_d;
  logic             same_addr;

  assign same_addr = bus.LOAD && (bus.WADDR == bus.RADDR);

  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    uninit_d  = 1'b0;

    if (bus.CLR) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
      written_d = '0;
    end else if (bus.LOAD) begin
      mem_d[bus.WADDR]     = bus.IN;
      written_d[bus.WADDR] = 1'b1;
    end

    // Read sees the pre-edge array; clear and forwarding override it.
    if (bus.RD_EN) begin
      valid_d = 1'b1;
      if (bus.CLR) begin
        out_d    = '0;
        uninit_d = 1'b1;
      end else if (FWD_EN && same_addr) begin
        out_d    = bus.IN;
        uninit_d = 1'b0;
      end else begin
        out_d    = mem_q[bus.RADDR];
        uninit_d = ~written_q[bus.RADDR];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      written_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      uninit_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      written_q <= written_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      uninit_q  <= uninit_d;
    end
  end

  assign bus.OUT       = out_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.WRITTEN   = written_q;
  assign bus.RD_UNINIT = uninit_q;

endmodule
